// File: rtl/operand_entry_ctrl.sv
// Button/switch front end for the 4-bit equality comparator: sync, debounce, press-edge,
// strobe arbitration (A before B) and operand-tracking FSM with registered status outputs.
module operand_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn_a,
    input  logic       btn_b,
    output logic [3:0] no,
    output logic       push1,
    output logic       push2,
    output logic       a_loaded,
    output logic       b_loaded,
    output logic       both_ready
);

    typedef enum logic [1:0] {EMPTY, HAVE_A, HAVE_B, READY} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Index 0 is button A, index 1 is button B.
    logic [1:0]       btn_raw;
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       s_q, s_d;
    logic [1:0]       db_q, db_d;
    logic [1:0]       db_dly_q, db_dly_d;
    logic [1:0]       armed_q, armed_d;
    logic [1:0]       warm_q, warm_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       press;

    logic [3:0] no_q, no_d;
    logic       push1_q, push1_d;
    logic       push2_q, push2_d;
    logic       pend_a_q, pend_a_d;
    logic       pend_b_q, pend_b_d;
    state_t     state_q, state_d;
    logic       a_loaded_q, a_loaded_d;
    logic       b_loaded_q, b_loaded_d;
    logic       both_ready_q, both_ready_d;

    assign btn_raw = {btn_b, btn_a};

    // A button only becomes armed once its synced level has been seen low after reset,
    // so a button held through reset cannot produce a strobe until re-pressed.
    always_comb begin
        sync1_d  = btn_raw;
        s_d      = sync1_q;
        db_dly_d = db_q;
        warm_d   = {warm_q[0], 1'b1};
        db_d     = db_q;
        armed_d  = armed_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                db_d[i]  = s_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            if (warm_q[1] && !s_q[i]) armed_d[i] = 1'b1;
        end
        press = db_q & ~db_dly_q & armed_q;
    end

    // Pending slots take priority over fresh events so strobes never collide.
    always_comb begin
        no_d     = no_q;
        push1_d  = 1'b0;
        push2_d  = 1'b0;
        pend_a_d = pend_a_q;
        pend_b_d = pend_b_q;
        if (pend_b_q) begin
            push2_d  = 1'b1;
            no_d     = sw;
            pend_b_d = press[1];
            if (press[0]) pend_a_d = 1'b1;
        end else if (pend_a_q) begin
            push1_d  = 1'b1;
            no_d     = sw;
            pend_a_d = press[0];
            if (press[1]) pend_b_d = 1'b1;
        end else if (press[0]) begin
            push1_d  = 1'b1;
            no_d     = sw;
            pend_b_d = press[1];
        end else if (press[1]) begin
            push2_d = 1'b1;
            no_d    = sw;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (push1_d)      state_d = HAVE_A;
                else if (push2_d) state_d = HAVE_B;
            end
            HAVE_A:  if (push2_d) state_d = READY;
            HAVE_B:  if (push1_d) state_d = READY;
            READY:   state_d = READY;
            default: state_d = EMPTY;
        endcase
        a_loaded_d   = (state_d == HAVE_A) || (state_d == READY);
        b_loaded_d   = (state_d == HAVE_B) || (state_d == READY);
        both_ready_d = both_ready_q || (state_q == READY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '0;
            s_q          <= '0;
            db_q         <= '0;
            db_dly_q     <= '0;
            armed_q      <= '0;
            warm_q       <= '0;
            cnt_q[0]     <= '0;
            cnt_q[1]     <= '0;
            no_q         <= '0;
            push1_q      <= 1'b0;
            push2_q      <= 1'b0;
            pend_a_q     <= 1'b0;
            pend_b_q     <= 1'b0;
            state_q      <= EMPTY;
            a_loaded_q   <= 1'b0;
            b_loaded_q   <= 1'b0;
            both_ready_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            s_q          <= s_d;
            db_q         <= db_d;
            db_dly_q     <= db_dly_d;
            armed_q      <= armed_d;
            warm_q       <= warm_d;
            cnt_q[0]     <= cnt_d[0];
            cnt_q[1]     <= cnt_d[1];
            no_q         <= no_d;
            push1_q      <= push1_d;
            push2_q      <= push2_d;
            pend_a_q     <= pend_a_d;
            pend_b_q     <= pend_b_d;
            state_q      <= state_d;
            a_loaded_q   <= a_loaded_d;
            b_loaded_q   <= b_loaded_d;
            both_ready_q <= both_ready_d;
        end
    end

    assign no         = no_q;
    assign push1      = push1_q;
    assign push2      = push2_q;
    assign a_loaded   = a_loaded_q;
    assign b_loaded   = b_loaded_q;
    assign both_ready = both_ready_q;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Directed bench for operand_entry_ctrl with a 4-cycle debounce.
module tb_operand_entry_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic       btn_a;
    logic       btn_b;
    logic [3:0] no;
    logic       push1;
    logic       push2;
    logic       a_loaded;
    logic       b_loaded;
    logic       both_ready;

    int checks = 0;
    int errors = 0;
    int p1_cnt = 0;
    int p2_cnt = 0;
    int both_hi = 0;
    int p1_base;
    int p2_base;

    operand_entry_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .btn_a      (btn_a),
        .btn_b      (btn_b),
        .no         (no),
        .push1      (push1),
        .push2      (push2),
        .a_loaded   (a_loaded),
        .b_loaded   (b_loaded),
        .both_ready (both_ready)
    );

    always #5 clk = ~clk;

    // Strobe counters sample the previous cycle's outputs at each rising edge.
    always @(posedge clk) begin
        if (push1) p1_cnt++;
        if (push2) p2_cnt++;
        if (push1 && push2) both_hi++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        sw    = 4'h0;
        btn_a = 1'b1;
        btn_b = 1'b0;
        step(3);
        check_eq("rst_no", {28'h0, no}, 32'h0);
        check_eq("rst_push1", {31'h0, push1}, 32'h0);
        check_eq("rst_push2", {31'h0, push2}, 32'h0);
        check_eq("rst_status", {29'h0, a_loaded, b_loaded, both_ready}, 32'h0);

        // Held through reset: no strobe while held, nor on release.
        rst = 1'b0;
        step(12);
        check_eq("held_no_push1", p1_cnt, 0);
        check_eq("held_a_loaded", {31'h0, a_loaded}, 32'h0);
        btn_a = 1'b0;
        step(8);
        check_eq("held_release_push1", p1_cnt, 0);

        // Clean A press: strobe visible in the cycle after edge 6.
        sw    = 4'hA;
        btn_a = 1'b1;
        step(6);
        check_eq("a_early", {31'h0, push1}, 32'h0);
        step(1);
        check_eq("a_push1", {31'h0, push1}, 32'h1);
        check_eq("a_no", {28'h0, no}, 32'hA);
        check_eq("a_loaded", {31'h0, a_loaded}, 32'h1);
        check_eq("a_push2", {31'h0, push2}, 32'h0);
        step(1);
        check_eq("a_one_cycle", {31'h0, push1}, 32'h0);
        btn_a = 1'b0;
        step(8);
        check_eq("a_single", p1_cnt, 1);

        // Glitch on B shorter than the debounce window.
        btn_b = 1'b1;
        step(3);
        btn_b = 1'b0;
        step(8);
        check_eq("glitch_push2", p2_cnt, 0);
        check_eq("glitch_b_loaded", {31'h0, b_loaded}, 32'h0);
        btn_b = 1'b1;
        step(10);
        check_eq("b_hold_push2", p2_cnt, 1);
        check_eq("b_loaded", {31'h0, b_loaded}, 32'h1);
        btn_b = 1'b0;
        step(8);
        check_eq("b_release_push2", p2_cnt, 1);
        check_eq("ab_both_ready", {31'h0, both_ready}, 32'h1);

        // Fresh start for simultaneous presses.
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        check_eq("rst2_status", {29'h0, a_loaded, b_loaded, both_ready}, 32'h0);
        step(4);
        sw    = 4'h5;
        btn_a = 1'b1;
        btn_b = 1'b1;
        step(7);
        check_eq("sim_push1", {30'h0, push1, push2}, 32'h2);
        check_eq("sim_no_a", {28'h0, no}, 32'h5);
        check_eq("sim_loaded_a", {30'h0, a_loaded, b_loaded}, 32'h2);
        step(1);
        check_eq("sim_push2", {30'h0, push1, push2}, 32'h1);
        check_eq("sim_no_b", {28'h0, no}, 32'h5);
        check_eq("sim_loaded_ab", {30'h0, a_loaded, b_loaded}, 32'h3);
        check_eq("sim_ready_early", {31'h0, both_ready}, 32'h0);
        step(1);
        check_eq("sim_both_ready", {31'h0, both_ready}, 32'h1);
        btn_a = 1'b0;
        btn_b = 1'b0;
        step(8);

        // Overwrite A while READY.
        p1_base = p1_cnt;
        p2_base = p2_cnt;
        sw    = 4'h3;
        btn_a = 1'b1;
        step(10);
        check_eq("ovr_push1_cnt", p1_cnt - p1_base, 1);
        check_eq("ovr_push2_cnt", p2_cnt - p2_base, 0);
        check_eq("ovr_no", {28'h0, no}, 32'h3);
        check_eq("ovr_status", {29'h0, a_loaded, b_loaded, both_ready}, 32'h7);
        btn_a = 1'b0;
        step(8);

        // Reset lands while B is pending.
        p2_base = p2_cnt;
        sw    = 4'h9;
        btn_a = 1'b1;
        btn_b = 1'b1;
        step(7);
        check_eq("pend_push1", {31'h0, push1}, 32'h1);
        rst = 1'b1;
        step(1);
        check_eq("pend_rst_push2", {31'h0, push2}, 32'h0);
        check_eq("pend_rst_status", {29'h0, a_loaded, b_loaded, both_ready}, 32'h0);
        check_eq("pend_rst_no", {28'h0, no}, 32'h0);
        step(1);
        rst = 1'b0;
        p1_base = p1_cnt;
        step(12);
        check_eq("pend_no_push2", p2_cnt - p2_base, 0);
        check_eq("pend_held_push1", p1_cnt - p1_base, 0);
        btn_a = 1'b0;
        btn_b = 1'b0;
        step(8);
        check_eq("pend_release_push2", p2_cnt - p2_base, 0);
        check_eq("never_both_strobes", both_hi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_entry_ctrl.md
Name: operand_entry_ctrl

Overview:
- Front end for the 4-bit two-operand equality comparator.
- Turns raw board push buttons and slide switches into clean single-cycle load strobes plus a registered 4-bit operand, which drive the comparator's `no`/`push1`/`push2` inputs.
- Provides input synchronisation, debouncing, press-edge detection and an operand-tracking state machine, with status LEDs for the user.

Parameters:
- DEBOUNCE_CYCLES, 500000, number of consecutive cycles a synchronised button level must differ from the debounced level before the debounced level flips (must be ≥ 2).
- CNT_W, 20, width of each debounce counter (2^CNT_W > DEBOUNCE_CYCLES).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- sw  input  4  raw slide-switch operand value.
- btn_a  input  1  raw, asynchronous, bouncy button: load operand A.
- btn_b  input  1  raw, asynchronous, bouncy button: load operand B.
- no  output  4  registered operand to comparator, valid whenever a strobe is high.
- push1  output  1  one-cycle strobe: comparator loads A from `no`.
- push2  output  1  one-cycle strobe: comparator loads B from `no`.
- a_loaded  output  1  A has been loaded since reset.
- b_loaded  output  1  B has been loaded since reset.
- both_ready  output  1  a_loaded & b_loaded, registered.

Behaviour:
- Reset:
  - All outputs are 0 and `no` = 4'h0.
  - Sync flops, debounced levels, edge flops and counters are cleared.
  - Pending-B flag is cleared and the FSM returns to EMPTY.
  - Reset mid-debounce or with a pending B discards that event. A button held through reset must be released and re-pressed to produce a strobe.
- Synchroniser: two-flop sync per button; sync output is `s`.
- Debounce, per button, with debounced level `db` and counter `cnt`:
  - If `s == db`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `db <= s`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - Pulses shorter than DEBOUNCE_CYCLES synced cycles produce no event. Release is debounced the same way.
- Press event: `db & ~db_q`, where `db_q` is `db` delayed one cycle. Release produces no event.
- Latency: take edge 0 as the first clock edge sampling `btn_a` = 1, with the button held stable. `push1` is high for exactly the one cycle following edge DEBOUNCE_CYCLES+2.
- Strobes:
  - On a press event, `no <= sw` and the matching strobe goes to 1 at the same edge. `no` holds its value until the next strobe.
  - `push1` and `push2` are never high in the same cycle.
- Simultaneous A and B press events in the same cycle:
  - A is issued first.
  - B sets `pend_b`; at the next edge `push2 <= 1` and `no <= sw` sampled at that edge.
  - If a new A event coincides with a pending B, pending B wins that cycle and A is held one cycle. At most one pending slot per button.
- FSM (2-bit state), tracking operands:
  - EMPTY: A strobe → HAVE_A; B strobe → HAVE_B.
  - HAVE_A: B strobe → READY; A strobe → stays HAVE_A (A overwritten).
  - HAVE_B: A strobe → READY; B strobe → stays HAVE_B.
  - READY: any strobe → stays READY (operand overwritten).
  - Outputs: `a_loaded` = state ∈ {HAVE_A, READY}; `b_loaded` = state ∈ {HAVE_B, READY}. Both update at the same edge as the causing strobe.
  - `both_ready` is asserted one cycle after entering READY and stays high until reset.
- No wrap-around concerns: counters saturate at DEBOUNCE_CYCLES-1 by construction.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
- **Reset state:** reset for 3 cycles with `btn_a` held high → all outputs 0, `no`=0. After release, no `push1` until the button is released and re-pressed.
- **Clean A press:** `sw`=4'hA, `btn_a` rises and holds → `push1`=1 for exactly one cycle after edge 6, `no`=4'hA, `a_loaded`=1, `push2`=0.
- **Glitch rejection:** `btn_b` high for 3 cycles then low → no `push2`, `b_loaded` stays 0. Then hold 10 cycles → exactly one `push2`, and no strobe on release.
- **Simultaneous presses:** `sw`=4'h5, `btn_a` and `btn_b` rise on the same edge → `push1` with `no`=5, next cycle `push2` with `no`=5. State READY, `both_ready`=1 one cycle later.
- **Overwrite in READY:** from READY set `sw`=4'h3 and press A → single `push1` with `no`=3, state stays READY, `both_ready` stays 1.
- **Reset mid-operation:** assert `rst` in the cycle a B event is pending → no `push2` is ever issued and all status outputs are 0 the cycle after reset.
